// File: rtl/usbf_hs_pkg.sv
// Shared definitions for the usbf 4-phase req/ack handshake blocks (rx and tx sides).
package usbf_hs_pkg;

  localparam logic [1:0] HS_IDLE  = 2'd0;
  localparam logic [1:0] HS_VALID = 2'd1;
  localparam logic [1:0] HS_ACK   = 2'd2;

  localparam int HS_DW_DEF    = 8;
  localparam int HS_STAGE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = HS_IDLE,
    ST_VALID = HS_VALID,
    ST_ACK   = HS_ACK
  } hs_state_e;

endpackage

// File: rtl/usbf_hs_rx_if.sv
// Handshake bundle: source-side req/data/ack plus consumer-side valid/ready/data.
interface usbf_hs_rx_if #(
  parameter int DW = usbf_hs_pkg::HS_DW_DEF
);
  logic          req_i;
  logic [DW-1:0] data_i;
  logic          ack_o;
  logic          vld_o;
  logic [DW-1:0] data_o;
  logic          rdy_i;

  modport slave (
    input  req_i, data_i, rdy_i,
    output ack_o, vld_o, data_o
  );

  modport master (
    output req_i, data_i, rdy_i,
    input  ack_o, vld_o, data_o
  );
endinterface

// File: rtl/level_sync.sv
// Multi-flop level synchronizer; STAGE must be at least 2.
module level_sync #(
  parameter int STAGE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGE-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < STAGE; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        usbf_gnrl_dffr #(.DW(1)) u_ff (
          .clk(clk), .rst_n(rst_n), .dnxt(d), .qout(sync_reg[gi])
        );
      end else begin : g_rest
        usbf_gnrl_dffr #(.DW(1)) u_ff (
          .clk(clk), .rst_n(rst_n), .dnxt(sync_reg[gi-1]), .qout(sync_reg[gi])
        );
      end
    end
  endgenerate

  assign q = sync_reg[STAGE-1];

endmodule

// File: rtl/usbf_gnrl_dffr.sv
// Generic register with asynchronous active-low reset to zero.
module usbf_gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) qout <= '0;
    else        qout <= dnxt;
  end

endmodule

// File: rtl/usbf_hs_rx.sv
// Destination side of a 4-phase req/ack crossing: captures a coherent word,
// hands it to a local valid/ready consumer, then acknowledges the source.
module usbf_hs_rx
  import usbf_hs_pkg::*;
#(
  parameter int DW    = HS_DW_DEF,
  parameter int STAGE = HS_STAGE_DEF,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  usbf_hs_rx_if.slave   hs,
  output logic          busy_o,
  output logic          proto_err_o,
  output logic [CW-1:0] xfer_cnt_o
);

  logic          req_s;
  logic [1:0]    state_q;
  hs_state_e     state_reg, state_next;
  logic          vld_reg, vld_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          busy_reg, busy_next;
  logic [DW-1:0] data_reg, data_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  level_sync #(.STAGE(STAGE)) u_req_sync (
    .clk(clk), .rst_n(rst_n), .d(hs.req_i), .q(req_s)
  );

  usbf_gnrl_dffr #(.DW(2))  u_state (.clk(clk), .rst_n(rst_n), .dnxt(state_next), .qout(state_q));
  usbf_gnrl_dffr #(.DW(1))  u_vld   (.clk(clk), .rst_n(rst_n), .dnxt(vld_next),   .qout(vld_reg));
  usbf_gnrl_dffr #(.DW(1))  u_ack   (.clk(clk), .rst_n(rst_n), .dnxt(ack_next),   .qout(ack_reg));
  usbf_gnrl_dffr #(.DW(1))  u_err   (.clk(clk), .rst_n(rst_n), .dnxt(err_next),   .qout(err_reg));
  usbf_gnrl_dffr #(.DW(1))  u_busy  (.clk(clk), .rst_n(rst_n), .dnxt(busy_next),  .qout(busy_reg));
  usbf_gnrl_dffr #(.DW(DW)) u_data  (.clk(clk), .rst_n(rst_n), .dnxt(data_next),  .qout(data_reg));
  usbf_gnrl_dffr #(.DW(CW)) u_cnt   (.clk(clk), .rst_n(rst_n), .dnxt(cnt_next),   .qout(cnt_reg));

  assign state_reg = hs_state_e'(state_q);

  // data_i is only trusted on the IDLE->VALID edge, when req_s proves it is stable.
  always_comb begin
    state_next = state_reg;
    vld_next   = vld_reg;
    ack_next   = ack_reg;
    err_next   = err_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        ack_next = 1'b0;
        if (req_s) begin
          data_next  = hs.data_i;
          vld_next   = 1'b1;
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (hs.rdy_i) begin
          vld_next = 1'b0;
          cnt_next = cnt_reg + CW'(1);
          if (req_s) begin
            ack_next   = 1'b1;
            state_next = ST_ACK;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        vld_next   = 1'b0;
        ack_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  assign hs.ack_o    = ack_reg;
  assign hs.vld_o    = vld_reg;
  assign hs.data_o   = data_reg;
  assign busy_o      = busy_reg;
  assign proto_err_o = err_reg;
  assign xfer_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_usbf_hs_rx.sv
// Scoreboard bench for usbf_hs_rx: stimulus pushes expected words, a monitor checks deliveries.
module tb_usbf_hs_rx;

  localparam int DW    = 8;
  localparam int STAGE = 2;
  localparam int CW    = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic          err;
    logic          ack;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy_o, proto_err_o;
  logic [CW-1:0] xfer_cnt_o;

  int   total = 0;
  int   bad   = 0;
  int   n_xfer = 0;
  logic exp_err = 1'b0;
  exp_t sb[$];

  usbf_hs_rx_if #(.DW(DW)) hs ();

  usbf_hs_rx #(.DW(DW), .STAGE(STAGE), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs),
    .busy_o(busy_o), .proto_err_o(proto_err_o), .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel=0 waits on ack_o, sel=1 on vld_o; the final comparison reports a timeout.
  task automatic wait_for(input string name, input int sel, input logic lvl);
    int k = 0;
    while (((sel == 0) ? hs.ack_o : hs.vld_o) !== lvl && k < 60) begin
      tick();
      k++;
    end
    check(name, (sel == 0) ? hs.ack_o : hs.vld_o, lvl);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic a);
    exp_t e;
    n_xfer++;
    e.data = d;
    e.cnt  = CW'(n_xfer);
    e.err  = exp_err;
    e.ack  = a;
    sb.push_back(e);
  endtask

  task automatic do_xfer(input logic [DW-1:0] d);
    push_exp(d, 1'b1);
    hs.data_i = d;
    hs.req_i  = 1'b1;
    wait_for("ack_rise_wait", 0, 1'b1);
    hs.req_i = 1'b0;
    wait_for("ack_fall_wait", 0, 1'b0);
  endtask

  // Monitor: a transfer is the edge following a cycle with vld_o && rdy_i.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && hs.vld_o && hs.rdy_i) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(hs.data_o), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("word_data", 32'(hs.data_o), 32'(e.data));
          @(posedge clk);
          #1;
          check("xfer_cnt", 32'(xfer_cnt_o), 32'(e.cnt));
          check("proto_err", 32'(proto_err_o), 32'(e.err));
          check("ack_after_xfer", 32'(hs.ack_o), 32'(e.ack));
          $display("xfer data=%02h cnt=%0d err=%0b ack=%0b", e.data, xfer_cnt_o, proto_err_o, hs.ack_o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    hs.req_i  = 1'b0;
    hs.data_i = '0;
    hs.rdy_i  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst_ack", 32'(hs.ack_o), 0);
    check("rst_vld", 32'(hs.vld_o), 0);
    check("rst_data", 32'(hs.data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(proto_err_o), 0);
    check("rst_cnt", 32'(xfer_cnt_o), 0);

    // Latency: req before E0, vld after E2, ack after E3; ack drops 3 edges after req falls.
    hs.rdy_i = 1'b1;
    push_exp(8'hA5, 1'b1);
    hs.data_i = 8'hA5;
    hs.req_i  = 1'b1;
    tick();
    tick();
    check("vld_early", 32'(hs.vld_o), 0);
    tick();
    check("vld_latency", 32'(hs.vld_o), 1);
    check("busy_valid", 32'(busy_o), 1);
    check("data_capture", 32'(hs.data_o), 32'h A5);
    tick();
    check("ack_latency", 32'(hs.ack_o), 1);
    hs.req_i = 1'b0;
    tick();
    tick();
    check("ack_hold", 32'(hs.ack_o), 1);
    tick();
    check("ack_drop", 32'(hs.ack_o), 0);
    check("busy_idle", 32'(busy_o), 0);
    $display("phase latency done cnt=%0d", xfer_cnt_o);

    // Consumer stall: word held for 20 cycles, ack withheld.
    hs.rdy_i = 1'b0;
    push_exp(8'h77, 1'b1);
    hs.data_i = 8'h77;
    hs.req_i  = 1'b1;
    wait_for("stall_vld_wait", 1, 1'b1);
    hs.data_i = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_vld", 32'(hs.vld_o), 1);
      check("stall_data", 32'(hs.data_o), 32'h77);
      check("stall_ack", 32'(hs.ack_o), 0);
    end
    hs.rdy_i = 1'b1;
    wait_for("stall_ack_wait", 0, 1'b1);
    hs.req_i = 1'b0;
    wait_for("stall_ack_fall", 0, 1'b0);
    $display("phase stall done cnt=%0d", xfer_cnt_o);

    // Early withdraw: word still delivered, error flagged, no ack.
    hs.rdy_i = 1'b0;
    exp_err  = 1'b1;
    push_exp(8'h3C, 1'b0);
    hs.data_i = 8'h3C;
    hs.req_i  = 1'b1;
    wait_for("wd_vld_wait", 1, 1'b1);
    hs.req_i = 1'b0;
    repeat (3) tick();
    hs.rdy_i = 1'b1;
    repeat (4) begin
      tick();
      check("wd_no_ack", 32'(hs.ack_o), 0);
    end
    check("wd_busy", 32'(busy_o), 0);
    check("wd_data_held", 32'(hs.data_o), 32'h3C);
    $display("phase withdraw done cnt=%0d err=%0b", xfer_cnt_o, proto_err_o);

    // Counter wrap: 14 more words take the count through 15 -> 0 -> 1.
    for (int i = 0; i < 14; i++) begin
      do_xfer(8'h10 + 8'(i));
    end
    check("wrap_cnt", 32'(xfer_cnt_o), 1);

    // Reset while in ACK: ack drops without a clock edge.
    do_xfer_no_drop(8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(hs.ack_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_err", 32'(proto_err_o), 0);
    check("arst_cnt", 32'(xfer_cnt_o), 0);
    hs.req_i = 1'b0;
    n_xfer  = 0;
    exp_err = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    do_xfer(8'h5A);
    check("post_rst_data", 32'(hs.data_o), 32'h5A);

    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic do_xfer_no_drop(input logic [DW-1:0] d);
    push_exp(d, 1'b1);
    hs.data_i = d;
    hs.req_i  = 1'b1;
    wait_for("inack_wait", 0, 1'b1);
  endtask

endmodule
